// File: rtl/pokey_kbd_scan.sv
// POKEY keyboard scanner: walks the 64-key matrix, samples kr1_L/kr2_L and debounces one key at a time.
// Optional build macro KBD_DEBOUNCE_EN selects the four-state debounce FSM; otherwise keys latch on first hit.
module pokey_kbd_scan #(
  parameter int          SCAN_DIV  = 114,
  parameter logic [5:0]  CTRL_POS  = 6'h00,
  parameter logic [5:0]  SHIFT_POS = 6'h10,
  parameter logic [5:0]  BREAK_POS = 6'h30
) (
  input  logic       o2,
  input  logic       reset,
  input  logic       scan_en,
  input  logic       kr1_L,
  input  logic       kr2_L,
  output logic [5:0] key_scan_L,
  output logic [5:0] compare_latch,
  output logic [7:0] keycode_latch,
  output logic       key_depr,
  output logic       shift_held,
  output logic       key_irq,
  output logic       break_irq
);

`ifdef KBD_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [5:0] scan_pos_q, scan_pos_d;
  logic [5:0] cmp_q, cmp_d;
  logic [7:0] code_q, code_d;
  logic       depr_q, depr_d;
  logic       shift_q, shift_d;
  logic       ctrl_q, ctrl_d;
  logic       brk_prev_q, brk_prev_d;
  logic       key_irq_q, key_irq_d;
  logic       brk_irq_q, brk_irq_d;

  logic sample;
  logic hit;
  logic at_cmp;

  assign sample = (div_cnt_q == DIV_LAST);
  assign hit    = ~kr1_L;
  assign at_cmp = (scan_pos_q == cmp_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    scan_pos_d = scan_pos_q;
    cmp_d      = cmp_q;
    code_d     = code_q;
    depr_d     = depr_q;
    shift_d    = shift_q;
    ctrl_d     = ctrl_q;
    brk_prev_d = brk_prev_q;
    key_irq_d  = 1'b0;
    brk_irq_d  = 1'b0;
    if (!scan_en) begin
      // Scan halted: restart from address 0, latches keep their contents.
      div_cnt_d  = '0;
      scan_pos_d = '0;
      state_d    = IDLE;
      depr_d     = 1'b0;
    end else if (!sample) begin
      div_cnt_d = div_cnt_q + 8'd1;
    end else begin
      div_cnt_d  = '0;
      scan_pos_d = scan_pos_q + 6'd1;
      if (scan_pos_q == SHIFT_POS) shift_d = ~kr2_L;
      if (scan_pos_q == CTRL_POS)  ctrl_d  = ~kr2_L;
      if (scan_pos_q == BREAK_POS) begin
        brk_irq_d  = ~kr2_L & brk_prev_q;
        brk_prev_d = kr2_L;
      end
      case (state_q)
`ifdef KBD_DEBOUNCE_EN
        IDLE: begin
          if (hit) begin
            cmp_d   = scan_pos_q;
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (at_cmp) begin
            if (hit) begin
              state_d   = HELD;
              code_d    = {ctrl_q, shift_q, cmp_q};
              depr_d    = 1'b1;
              key_irq_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HELD: begin
          if (at_cmp && !hit) state_d = RELEASE;
        end
        RELEASE: begin
          if (at_cmp) begin
            if (hit) begin
              state_d = HELD;
            end else begin
              state_d = IDLE;
              depr_d  = 1'b0;
            end
          end
        end
`else
        IDLE: begin
          if (hit) begin
            cmp_d     = scan_pos_q;
            code_d    = {ctrl_q, shift_q, scan_pos_q};
            depr_d    = 1'b1;
            key_irq_d = 1'b1;
            state_d   = HELD;
          end
        end
        HELD: begin
          if (at_cmp && !hit) begin
            state_d = IDLE;
            depr_d  = 1'b0;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge o2) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      scan_pos_q <= '0;
      cmp_q      <= '0;
      code_q     <= '0;
      depr_q     <= 1'b0;
      shift_q    <= 1'b0;
      ctrl_q     <= 1'b0;
      brk_prev_q <= 1'b1;
      key_irq_q  <= 1'b0;
      brk_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      scan_pos_q <= scan_pos_d;
      cmp_q      <= cmp_d;
      code_q     <= code_d;
      depr_q     <= depr_d;
      shift_q    <= shift_d;
      ctrl_q     <= ctrl_d;
      brk_prev_q <= brk_prev_d;
      key_irq_q  <= key_irq_d;
      brk_irq_q  <= brk_irq_d;
    end
  end

  assign key_scan_L    = ~scan_pos_q;
  assign compare_latch = cmp_q;
  assign keycode_latch = code_q;
  assign key_depr      = depr_q;
  assign shift_held    = shift_q;
  assign key_irq       = key_irq_q;
  assign break_irq     = brk_irq_q;

endmodule

// File: doc/pokey_kbd_scan.md
# pokey_kbd_scan

Keyboard scan controller for the POKEY I/O section. It steps a 6-bit scan address across the 64-key matrix and samples the kr1_L/kr2_L return lines. A debounce state machine then decides when a key press is real: it loads the compare latch, updates the keycode latch and key_depr, and raises interrupt pulses. It sits beside the pot-scan logic under the POKEY I/O controller; the IRQ enable/status register logic lives elsewhere and consumes the pulses produced here.

## Interface
- SCAN_DIV, 114: o2 cycles each scan address is held (dwell); legal range 2..255.
- CTRL_POS, 6'h00: scan address at which kr2_L reports CTRL.
- SHIFT_POS, 6'h10: scan address at which kr2_L reports SHIFT.
- BREAK_POS, 6'h30: scan address at which kr2_L reports BREAK.

- o2  in  1  phase-2 system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- scan_en  in  1  keyboard scan enable (SKCTL debounce/scan bit).
- kr1_L  in  1  key return line, low = key at current address pressed.
- kr2_L  in  1  modifier/break return line, low = pressed.
- key_scan_L  out  6  current scan address, inverted (key_scan_L = ~scan_pos).
- compare_latch  out  6  address of the key under debounce.
- keycode_latch  out  8  {ctrl, shift, code[5:0]} of the last accepted key.
- key_depr  out  1  a key is currently held (KBCODE/SKSTAT bit).
- shift_held  out  1  SHIFT held as of its last sample.
- key_irq  out  1  one-cycle pulse when a new key is accepted.
- break_irq  out  1  one-cycle pulse on a BREAK press.

## Operation
- Scan counter.
  - div_cnt counts 0..SCAN_DIV-1.
  - The sample point is the cycle with div_cnt==SCAN_DIV-1.
  - At the sample point, kr1_L/kr2_L are evaluated for scan_pos; scan_pos then increments mod 64 (63 wraps to 0).
- kr2_L at a sample point:
  - At SHIFT_POS, shift_held <= ~kr2_L.
  - At CTRL_POS, ctrl_held <= ~kr2_L.
  - At BREAK_POS, break_irq pulses if kr2_L is low and the previous BREAK sample was high; the previous-sample flag updates every scan.
- Debounce FSM, evaluated only at sample points. Let p = scan_pos and hit = ~kr1_L.
  - IDLE: if hit, compare_latch <= p and go to CONFIRM.
  - CONFIRM: at p==compare_latch, if hit go to HELD, latch the key, set key_depr=1 and pulse key_irq; if not hit go to IDLE.
  - HELD: at p==compare_latch, if not hit go to RELEASE.
  - RELEASE: at p==compare_latch, if not hit go to IDLE and clear key_depr; if hit go back to HELD with no irq and no relatch.
  - In every state except IDLE, hits at other addresses are ignored.
- Latching a key means keycode_latch <= {ctrl_held, shift_held, compare_latch}.
- Rollover: only the first key detected is tracked; a second key is recognised only after the FSM returns to IDLE.
- scan_en=0:
  - div_cnt, scan_pos and the FSM are forced to 0/IDLE; key_depr=0; no pulses.
  - keycode_latch, compare_latch, shift_held and ctrl_held hold their values.
- Reset values:
  - key_scan_L=6'h3F; compare_latch=0; keycode_latch=0.
  - key_depr=0; shift_held=0; key_irq=0; break_irq=0.
  - FSM=IDLE; div_cnt=0; BREAK previous-sample flag=1 (released).

## Timing
- Scan address dwell: SCAN_DIV cycles. Full scan: 64*SCAN_DIV cycles.
- Sampled inputs affect registered outputs on the edge that ends the sample cycle. key_irq/break_irq are high for exactly that one following cycle.
- With debounce, press-to-irq latency is one full scan (64*SCAN_DIV cycles) after first detection. Release-to-key_depr-clear latency is two full scans.
- Reset asserted mid-scan takes effect on the next edge and overrides scan_en. A pulse in flight is dropped.
- scan_en rising: scanning starts at address 0, with its first sample SCAN_DIV cycles later.

## Configuration
- KBD_DEBOUNCE_EN defined: the four-state FSM above.
- KBD_DEBOUNCE_EN undefined:
  - CONFIRM and RELEASE are removed.
  - IDLE goes directly to HELD on the first hit: latch, set key_depr and pulse key_irq at that sample.
  - HELD goes directly to IDLE on the first miss at compare_latch.

## Test plan
- Reset, then scan_en=1 with SCAN_DIV=4 -> key_scan_L steps 3F,3E,… every 4 cycles and wraps 00->3F after 256 cycles; all other outputs stay 0.
- Hold key 6'h25 low (debounce on) -> compare_latch=25 at the first sample; key_irq pulses once exactly 256 cycles later; keycode_latch=8'h25; key_depr=1.
- With SHIFT held, press key 6'h0A -> keycode_latch=8'h4A. Then release -> key_depr clears two scans after release; no further key_irq.
- Press 6'h05 for one sample only (glitch) -> FSM returns to IDLE; no key_irq; keycode_latch unchanged. Without KBD_DEBOUNCE_EN, the same glitch yields key_irq and keycode_latch=8'h05.
- Hold keys 6'h10 and 6'h20 together -> only 6'h10 is accepted. After 6'h10 is released, 6'h20 is accepted with a second key_irq.
- Hold kr2_L low at BREAK_POS for 3 scans -> a single break_irq pulse. Drop scan_en mid-press -> key_depr=0, keycode_latch retained.
